// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and fetches 32-bit instructions over a
// req/ack handshake. It feeds a registered {pc, inst, valid} slot to decode.
// A single-entry buffer catches a fetch that completes while decode is
// stalled, so no instruction is lost or duplicated.
module if_stage #(
    parameter logic [63:0] PC_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall_if,
    input  logic        jump_if,
    input  logic [63:0] jump_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [63:0] pc_id,
    output logic [31:0] inst_id,
    output logic        valid_id
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {FETCH = 1'b0, FULL = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [63:0] pc_id_q, pc_id_d;
    logic [31:0] inst_id_q, inst_id_d;
    logic        valid_id_q, valid_id_d;
    logic        xfer;
    logic [63:0] jump_tgt;

    // Request whenever the buffer is free; the address is the live PC.
    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    // A handshake coinciding with a redirect belongs to the dead path.
    assign xfer      = imem_req & imem_ack & ~jump_if;
    // Redirect targets are forced word-aligned.
    assign jump_tgt  = jump_pc & ~64'h3;

    assign pc_id    = pc_id_q;
    assign inst_id  = inst_id_q;
    assign valid_id = valid_id_q;

    // Next-state: redirect > stall > drain buffer > direct fetch > bubble.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        pc_id_d    = pc_id_q;
        inst_id_d  = inst_id_q;
        valid_id_d = valid_id_q;
        if (jump_if) begin
            pc_d       = jump_tgt;
            state_d    = FETCH;
            valid_id_d = 1'b0;
        end else if (stall_if) begin
            if (xfer) begin
                buf_pc_d   = pc_q;
                buf_inst_d = imem_rdata;
                pc_d       = pc_q + 64'd4;
                state_d    = FULL;
            end
        end else if (state_q == FULL) begin
            // PC was already advanced when the buffer was filled.
            pc_id_d    = buf_pc_q;
            inst_id_d  = buf_inst_q;
            valid_id_d = 1'b1;
            state_d    = FETCH;
        end else if (xfer) begin
            pc_id_d    = pc_q;
            inst_id_d  = imem_rdata;
            valid_id_d = 1'b1;
            pc_d       = pc_q + 64'd4;
        end else begin
            valid_id_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= FETCH;
            pc_q       <= PC_RESET;
            buf_pc_q   <= 64'h0;
            buf_inst_q <= NOP;
            pc_id_q    <= 64'h0;
            inst_id_q  <= NOP;
            valid_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            pc_id_q    <= pc_id_d;
            inst_id_q  <= inst_id_d;
            valid_id_q <= valid_id_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a queue-based fetch model checked every cycle, directed
// scenarios with literal expectations, then a randomized run.
module tb_if_stage;

    localparam logic [63:0] PCR = 64'h1000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall_if = 1'b0;
    logic        jump_if = 1'b0;
    logic [63:0] jump_pc = 64'h0;
    logic        imem_ack = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [63:0] pc_id;
    logic [31:0] inst_id;
    logic        valid_id;
    logic [31:0] junk = 32'h0;
    logic        chk_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    if_stage #(.PC_RESET(PCR)) dut (
        .clk(clk), .rstn(rstn), .stall_if(stall_if), .jump_if(jump_if),
        .jump_pc(jump_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_id(pc_id),
        .inst_id(inst_id), .valid_id(valid_id)
    );

    always #5 clk = ~clk;

    // Instruction memory contents are a fixed hash of the address.
    function automatic logic [31:0] mem(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0003;
    endfunction

    // Data is only meaningful on ack; otherwise the bus carries junk.
    assign imem_rdata = imem_ack ? mem(imem_addr) : junk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: fetched-but-undelivered instructions live in a queue; a request
    // is made only when that queue is empty.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    ent_t        m_e;
    logic [63:0] m_pc;
    logic [63:0] m_pcid;
    logic [31:0] m_inst;
    logic        m_vld;

    always @(posedge clk) begin
        if (!rstn) begin
            m_pc   = PCR;
            q.delete();
            m_pcid = 64'h0;
            m_inst = NOP;
            m_vld  = 1'b0;
        end else if (jump_if) begin
            m_pc = {jump_pc[63:2], 2'b00};
            q.delete();
            m_vld = 1'b0;
        end else begin
            if (q.size() == 0 && imem_ack) begin
                m_e.pc   = m_pc;
                m_e.inst = mem(m_pc);
                q.push_back(m_e);
                m_pc = m_pc + 64'd4;
            end
            if (!stall_if) begin
                if (q.size() > 0) begin
                    m_e    = q.pop_front();
                    m_pcid = m_e.pc;
                    m_inst = m_e.inst;
                    m_vld  = 1'b1;
                end else begin
                    m_vld = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_req", imem_req, 64'(q.size() == 0));
            if (q.size() == 0) chk("m_addr", imem_addr, m_pc);
            chk("m_valid", valid_id, m_vld);
            if (m_vld) begin
                chk("m_pc_id", pc_id, m_pcid);
                chk("m_inst_id", inst_id, m_inst);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        junk = $urandom;
    endtask

    initial begin
        // Reset
        rstn = 1'b0;
        tick();
        tick();
        chk("rst_valid", valid_id, 0);
        chk("rst_pc_id", pc_id, 0);
        chk("rst_inst", inst_id, NOP);
        chk("rst_addr", imem_addr, PCR);
        chk_en   = 1'b1;
        rstn     = 1'b1;
        imem_ack = 1'b1;
        // Back-to-back fetches
        tick(); chk("seq0", pc_id, 64'h1000); chk("seq0_inst", inst_id, mem(64'h1000));
        tick(); chk("seq1", pc_id, 64'h1004);
        tick(); chk("seq2", pc_id, 64'h1008); chk("seq2_inst", inst_id, mem(64'h1008));
        chk("seq2_valid", valid_id, 1);
        // ack withheld three cycles at 0x100C
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_addr", imem_addr, 64'h100C);
            chk("wait_valid", valid_id, 0);
        end
        imem_ack = 1'b1;
        tick(); chk("wait_done", pc_id, 64'h100C); chk("wait_done_v", valid_id, 1);
        // Four-cycle stall while 0x100C sits in decode
        stall_if = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_hold", pc_id, 64'h100C);
            chk("stall_req", imem_req, 0);
        end
        stall_if = 1'b0;
        tick(); chk("drain", pc_id, 64'h1010); chk("drain_addr", imem_addr, 64'h1014);
        tick(); chk("after_drain", pc_id, 64'h1014); chk("after_drain_v", valid_id, 1);
        // Redirect coinciding with an ack for 0x1018
        jump_if = 1'b1; jump_pc = 64'h2003;
        tick(); chk("jmp_valid", valid_id, 0); chk("jmp_addr", imem_addr, 64'h2000);
        jump_if = 1'b0;
        tick(); chk("jmp_tgt", pc_id, 64'h2000); chk("jmp_tgt_v", valid_id, 1);
        // Redirect + stall while the buffer is full
        stall_if = 1'b1;
        tick(); chk("full_req", imem_req, 0);
        jump_if = 1'b1; jump_pc = 64'h3000;
        tick(); chk("js_valid", valid_id, 0); chk("js_addr", imem_addr, 64'h3000);
        jump_if = 1'b0; stall_if = 1'b0;
        tick(); chk("js_tgt", pc_id, 64'h3000);
        // PC wrap, then reset while FULL
        jump_if = 1'b1; jump_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(); jump_if = 1'b0;
        tick(); chk("wrap_pc_id", pc_id, 64'hFFFF_FFFF_FFFF_FFFC); chk("wrap_addr", imem_addr, 0);
        stall_if = 1'b1;
        tick(); chk("wrap_full", imem_req, 0);
        rstn = 1'b0;
        tick(); chk("mid_rst_v", valid_id, 0); chk("mid_rst_addr", imem_addr, PCR);
        chk("mid_rst_req", imem_req, 1);
        rstn = 1'b1; stall_if = 1'b0;
        tick(); chk("post_rst", pc_id, PCR);
        // Randomized traffic checked by the model
        for (int i = 0; i < 4000; i++) begin
            tick();
            rstn     = ($urandom_range(0, 199) != 0);
            stall_if = ($urandom_range(0, 9) < 3);
            imem_ack = ($urandom_range(0, 9) < 7);
            jump_if  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                jump_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else
                jump_pc = {32'h0, $urandom};
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
